// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: sequencer state, ROB ID width, lap depth helper.
package rob_pkg;

  // Sequencer phases: wipe valid_mem, hand out IDs, wait for the lap to retire.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ALLOC = 2'd1,
    DRAIN = 2'd2
  } rob_seq_state_t;

  // Default ROB index width; also used by the valid_mem integration wrapper.
  localparam int ROB_AW = 4;

  typedef logic [ROB_AW-1:0] rob_id_t;

  // Entries per lap for a given index width.
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/rob_seq_ctrl.sv
// In-order ROB sequencer around valid_mem: allocates IDs at the tail, forwards
// completions as valid-bit sets, retires from the head, recycles a lap with
// one global clear once every ID in it has retired.
module rob_seq_ctrl
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req_i,
  output logic                  alloc_gnt_o,
  output logic [ADDR_WIDTH-1:0] alloc_id_o,
  input  logic                  resp_valid_i,
  input  logic [ADDR_WIDTH-1:0] resp_id_i,
  output logic                  vm_set_o,
  output logic [ADDR_WIDTH-1:0] vm_addr_write_o,
  output logic                  vm_clear_o,
  output logic [ADDR_WIDTH-1:0] vm_addr_read_o,
  input  logic                  vm_valid_i,
  output logic                  ret_valid_o,
  input  logic                  ret_ready_i,
  output logic [ADDR_WIDTH-1:0] ret_id_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  err_o
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(depth(ADDR_WIDTH));
  localparam logic [PW-1:0] DEPTH_M1 = PW'(depth(ADDR_WIDTH) - 1);
  localparam logic [PW-1:0] ONE      = PW'(1);

  typedef logic [ADDR_WIDTH-1:0] id_t;

  rob_seq_state_t state_q, state_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic           err_q, err_d;

  logic          alloc_hs, ret_hs, resp_in_rng;
  logic [PW-1:0] count;
  logic [PW-1:0] resp_ext;

  // Handshakes, occupancy and the outstanding-window check.
  always_comb begin
    resp_ext    = {1'b0, resp_id_i};
    count       = tail_q - head_q;
    alloc_hs    = alloc_req_i && (state_q == ALLOC) && (tail_q < DEPTH_P);
    ret_valid_o = vm_valid_i && (head_q < tail_q) && (state_q != CLEAR);
    ret_hs      = ret_valid_o && ret_ready_i;
    resp_in_rng = (resp_ext >= head_q) && (resp_ext < tail_q);
  end

  // Port-level views of the sequencer state.
  always_comb begin
    alloc_gnt_o     = alloc_hs;
    alloc_id_o      = id_t'(tail_q[ADDR_WIDTH-1:0]);
    vm_set_o        = resp_valid_i && (state_q != CLEAR);
    vm_addr_write_o = resp_id_i;
    vm_clear_o      = (state_q == CLEAR);
    vm_addr_read_o  = id_t'(head_q[ADDR_WIDTH-1:0]);
    ret_id_o        = id_t'(head_q[ADDR_WIDTH-1:0]);
    count_o         = count;
    empty_o         = (count == '0);
    full_o          = (tail_q == DEPTH_P);
    err_o           = err_q;
  end

  // Next state, pointer advance and sticky error.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q;
    // Responses during CLEAR would be wiped by the clear, so they are errors too.
    if (resp_valid_i && ((state_q == CLEAR) || !resp_in_rng))
      err_d = 1'b1;
    case (state_q)
      CLEAR: begin
        state_d = ALLOC;
        head_d  = '0;
        tail_d  = '0;
      end
      ALLOC: begin
        if (alloc_hs) tail_d = tail_q + ONE;
        if (ret_hs)   head_d = head_q + ONE;
        if (alloc_hs && (tail_q == DEPTH_M1))
          state_d = DRAIN;
        // Idle with a partly used lap and nothing in flight: recycle early so
        // the next burst starts on a fresh lap.
        else if ((count == '0) && (tail_q != '0) && !alloc_req_i && !ret_hs)
          state_d = CLEAR;
      end
      DRAIN: begin
        if (ret_hs) begin
          head_d = head_q + ONE;
          if (head_q == DEPTH_M1) state_d = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // State register; reset lands in CLEAR so valid_mem is wiped before reuse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      head_q  <= '0;
      tail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rob_seq_ctrl.sv
// Directed bench for rob_seq_ctrl with a behavioural valid_mem alongside.
module tb_rob_seq_ctrl;

  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req_i, alloc_gnt_o;
  logic [AW-1:0] alloc_id_o;
  logic          resp_valid_i;
  logic [AW-1:0] resp_id_i;
  logic          vm_set_o, vm_clear_o, vm_valid_i;
  logic [AW-1:0] vm_addr_write_o, vm_addr_read_o;
  logic          ret_valid_o, ret_ready_i;
  logic [AW-1:0] ret_id_o;
  logic [AW:0]   count_o;
  logic          empty_o, full_o, err_o;

  int vecs = 0;
  int errs = 0;

  rob_seq_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_id_o(alloc_id_o),
    .resp_valid_i(resp_valid_i), .resp_id_i(resp_id_i),
    .vm_set_o(vm_set_o), .vm_addr_write_o(vm_addr_write_o), .vm_clear_o(vm_clear_o),
    .vm_addr_read_o(vm_addr_read_o), .vm_valid_i(vm_valid_i),
    .ret_valid_o(ret_valid_o), .ret_ready_i(ret_ready_i), .ret_id_o(ret_id_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // valid_mem: synchronous set, global clear, asynchronous read.
  logic [DEPTH-1:0] vmem;
  always @(posedge clk) begin
    if (vm_clear_o)    vmem <= '0;
    else if (vm_set_o) vmem[vm_addr_write_o] <= 1'b1;
  end
  assign vm_valid_i = vmem[vm_addr_read_o];

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 after the edge, checks follow 1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; alloc_req_i = 1'b1; resp_valid_i = 1'b0; resp_id_i = '0; ret_ready_i = 1'b0;
    tick(); tick();
    settle();
    chk("rst_gnt", alloc_gnt_o, 0);
    chk("rst_retv", ret_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_clear", vm_clear_o, 1);

    // Release: one more clear cycle, then IDs 0,1,2 back to back.
    rst = 1'b0;
    settle();
    chk("post_rst_clear", vm_clear_o, 1);
    chk("post_rst_gnt", alloc_gnt_o, 0);
    tick(); settle();
    chk("clear_done", vm_clear_o, 0);
    for (int i = 0; i < 3; i++) begin
      chk("gnt_seq", alloc_gnt_o, 1);
      chk("id_seq", alloc_id_o, i);
      tick(); settle();
    end
    chk("count3", count_o, 3);

    // Response to non-outstanding ID 7: forwarded, error flagged next cycle.
    alloc_req_i = 1'b0; resp_valid_i = 1'b1; resp_id_i = 4'd7;
    settle();
    chk("bad_resp_fwd", vm_set_o, 1);
    chk("err_not_yet", err_o, 0);
    tick();
    resp_valid_i = 1'b0; alloc_req_i = 1'b1;
    settle();
    chk("err_set", err_o, 1);
    chk("err_head_id", ret_id_o, 0);
    chk("err_no_retv", ret_valid_o, 0);
    chk("gnt_id3", alloc_id_o, 3);
    tick();

    // Out-of-order completion: 2 then 0; head 0 retires, then waits for 1.
    alloc_req_i = 1'b0; resp_valid_i = 1'b1; resp_id_i = 4'd2;
    settle();
    chk("count4", count_o, 4);
    chk("retv_r2", ret_valid_o, 0);
    tick();
    resp_id_i = 4'd0;
    settle();
    chk("retv_same_cyc", ret_valid_o, 0);
    tick();
    resp_valid_i = 1'b0; ret_ready_i = 1'b1;
    settle();
    chk("retv0", ret_valid_o, 1);
    chk("retid0", ret_id_o, 0);
    tick();
    ret_ready_i = 1'b0;
    settle();
    chk("retv_wait1", ret_valid_o, 0);
    chk("retid1", ret_id_o, 1);
    chk("err_sticky", err_o, 1);
    resp_valid_i = 1'b1; resp_id_i = 4'd1;
    tick();
    resp_valid_i = 1'b0; ret_ready_i = 1'b1;
    settle();
    chk("retv1", ret_valid_o, 1);
    tick(); settle();
    chk("retv2", ret_valid_o, 1);
    chk("retid2", ret_id_o, 2);
    tick();
    ret_ready_i = 1'b0; resp_valid_i = 1'b1; resp_id_i = 4'd3;
    settle();
    chk("retv_wait3", ret_valid_o, 0);
    chk("count1", count_o, 1);
    tick();
    resp_valid_i = 1'b0; ret_ready_i = 1'b1;
    settle();
    chk("retv3", ret_valid_o, 1);
    tick();
    ret_ready_i = 1'b0;
    settle();
    chk("drained_empty", empty_o, 1);
    chk("early_recycle_pre", vm_clear_o, 0);
    tick(); settle();
    chk("early_recycle", vm_clear_o, 1);
    tick();
    alloc_req_i = 1'b1;
    settle();
    chk("recycle_done", vm_clear_o, 0);
    chk("recycle_id0", alloc_id_o, 0);

    // Fresh lap: IDs 0..4, completing 0 alongside the grant of 4.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin resp_valid_i = 1'b1; resp_id_i = 4'd0; end
      tick();
    end
    resp_valid_i = 1'b0; ret_ready_i = 1'b1;
    settle();
    chk("count5", count_o, 5);
    chk("both_gnt", alloc_gnt_o, 1);
    chk("both_id", alloc_id_o, 5);
    chk("both_retv", ret_valid_o, 1);
    tick();
    ret_ready_i = 1'b0;
    settle();
    chk("both_count", count_o, 5);
    chk("both_head", ret_id_o, 1);
    chk("both_tail", alloc_id_o, 6);

    // Fill the lap to DEPTH.
    for (int i = 6; i < DEPTH; i++) begin
      chk("fill_id", alloc_id_o, i);
      tick(); settle();
    end
    chk("full", full_o, 1);
    chk("full_no_gnt", alloc_gnt_o, 0);
    chk("full_count", count_o, 15);

    // Complete 1..15 one per cycle while retiring behind them.
    ret_ready_i = 1'b1;
    for (int c = 0; c < 15; c++) begin
      resp_valid_i = 1'b1; resp_id_i = AW'(c + 1);
      settle();
      chk("drain_retv", ret_valid_o, (c >= 1) ? 1 : 0);
      tick();
    end
    resp_valid_i = 1'b0;
    settle();
    chk("last_retv", ret_valid_o, 1);
    chk("last_retid", ret_id_o, 15);
    chk("last_full", full_o, 1);
    tick(); settle();
    chk("lap_clear", vm_clear_o, 1);
    chk("lap_clear_retv", ret_valid_o, 0);
    chk("lap_clear_gnt", alloc_gnt_o, 0);
    tick(); settle();
    chk("lap_clear_1cyc", vm_clear_o, 0);
    chk("new_lap_gnt", alloc_gnt_o, 1);
    chk("new_lap_id", alloc_id_o, 0);

    // Build head=3, tail=9, then reset mid-cycle.
    for (int t = 0; t < 9; t++) begin
      resp_valid_i = (t >= 1 && t <= 3);
      resp_id_i = AW'(t - 1);
      tick();
    end
    resp_valid_i = 1'b0; alloc_req_i = 1'b0; ret_ready_i = 1'b0;
    settle();
    chk("mid_count", count_o, 6);
    chk("mid_head", ret_id_o, 3);
    chk("mid_tail", alloc_id_o, 9);
    #2;
    rst = 1'b1;
    alloc_req_i = 1'b1;
    #1;
    chk("async_count", count_o, 0);
    chk("async_empty", empty_o, 1);
    chk("async_gnt", alloc_gnt_o, 0);
    chk("async_retv", ret_valid_o, 0);
    chk("async_clear", vm_clear_o, 1);
    chk("async_err", err_o, 0);
    chk("async_full", full_o, 0);
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rel_clear", vm_clear_o, 1);
    tick(); settle();
    chk("rel_clear_end", vm_clear_o, 0);
    chk("rel_gnt", alloc_gnt_o, 1);
    chk("rel_id0", alloc_id_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rob_seq_ctrl.md
Name: rob_seq_ctrl

Overview:
In-order sequencing controller for the reorder buffer, wrapped around valid_mem.
- Upstream: allocates ROB IDs in order (tail) and forwards completion responses as valid-bit sets.
- Downstream: polls the valid bit at the head and retires entries in order through a valid/ready handshake.
- valid_mem clears only globally, so IDs are issued in laps of DEPTH. A lap is recycled with one global clear once every entry in it has retired.

Parameters:
ADDR_WIDTH, 4, ROB index width; DEPTH = 2**ADDR_WIDTH entries per lap

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
alloc_req_i  in  1  request for a new ROB ID
alloc_gnt_o  out  1  ID granted this cycle
alloc_id_o  out  ADDR_WIDTH  granted ID (tail index)
resp_valid_i  in  1  completion for resp_id_i
resp_id_i  in  ADDR_WIDTH  completing ID
vm_set_o  out  1  to valid_mem set_i
vm_addr_write_o  out  ADDR_WIDTH  to valid_mem addr_write_i
vm_clear_o  out  1  to valid_mem clear_i
vm_addr_read_o  out  ADDR_WIDTH  to valid_mem addr_read_i (head index)
vm_valid_i  in  1  from valid_mem read_data_o (async read of head)
ret_valid_o  out  1  head entry complete, ready to retire
ret_ready_i  in  1  consumer accepts retire
ret_id_o  out  ADDR_WIDTH  retiring ID
count_o  out  ADDR_WIDTH+1  outstanding entries (tail - head)
empty_o  out  1  count_o == 0
full_o  out  1  lap exhausted (tail == DEPTH)
err_o  out  1  sticky: response to a non-outstanding ID

Behaviour:
- Registers:
  - head, tail: ADDR_WIDTH+1 bits, range 0..DEPTH.
  - state: {CLEAR, ALLOC, DRAIN}.
  - err: 1 bit.
- Reset: state=CLEAR, head=0, tail=0, err=0.
  - alloc_gnt_o=0, ret_valid_o=0, count_o=0, empty_o=1, full_o=0, err_o=0.
  - vm_clear_o=1 during reset and for the first cycle after release.
  - Any reset, including one mid-lap, therefore wipes valid_mem before new IDs are issued.
- Combinational outputs:
  - alloc_gnt_o = alloc_req_i && state==ALLOC && tail<DEPTH.
  - alloc_id_o = tail[ADDR_WIDTH-1:0].
  - vm_set_o = resp_valid_i && state!=CLEAR.
  - vm_addr_write_o = resp_id_i.
  - vm_addr_read_o = ret_id_o = head[ADDR_WIDTH-1:0].
  - ret_valid_o = vm_valid_i && head<tail && state!=CLEAR.
  - vm_clear_o = (state==CLEAR).
- Pointer updates:
  - On an alloc handshake: tail += 1.
  - On a retire handshake (ret_valid_o && ret_ready_i): head += 1.
  - Both in the same cycle: both pointers advance and count_o is unchanged.
- Latency:
  - Grant is same-cycle.
  - A resp to the head ID raises ret_valid_o the next cycle (valid_mem write is synchronous, its read is async).
  - Minimum resp-to-retire latency is 1 cycle.
- Outstanding check:
  - resp_valid_i with resp_id_i outside [head, tail), or in state CLEAR, sets err (sticky until rst).
  - The response is still forwarded except in CLEAR.
- State machine:
  - CLEAR -> ALLOC unconditionally after 1 cycle; head<=0, tail<=0.
  - ALLOC -> DRAIN when an alloc handshake makes tail == DEPTH.
  - ALLOC -> CLEAR (early recycle) when count_o==0, tail!=0, alloc_req_i==0 and no retire this cycle.
  - DRAIN: no grants; full_o=1. DRAIN -> CLEAR when head == DEPTH after a retire, i.e. the lap is fully retired.
- Boundaries:
  - count_o reaches DEPTH exactly; tail never exceeds DEPTH.
  - Retire of the last entry and the transition to CLEAR occur in back-to-back cycles; ret_valid_o=0 in CLEAR.
  - ret_valid_o may drop without ret_ready_i only via reset; once asserted it is held until the handshake, because valid bits only clear in CLEAR, which requires head==tail.

Decomposition:
- Shared package rob_pkg:
  - state enum rob_seq_state_t {CLEAR, ALLOC, DRAIN}.
  - function depth(aw) = 2**aw.
  - ROB ID typedef parameterised by ADDR_WIDTH, shared with valid_mem's integration wrapper.
- Single module; no sub-module warranted.

Test Plan:
- Reset release -> vm_clear_o=1 for exactly 1 cycle, then alloc_req_i=1 grants IDs 0,1,2 on consecutive cycles; count_o=3.
- Allocate 0..3; resp IDs 2,0 -> ret_valid_o rises the cycle after resp 0 with ret_id_o=0. After retiring 0, ret_valid_o=0 (ID 1 pending). Resp 1 -> retire 1, then 2.
- ADDR_WIDTH=4: allocate 16 IDs back-to-back -> full_o=1, alloc_gnt_o=0 with alloc_req_i held. Complete and retire all 16 -> 1-cycle vm_clear_o, next grant is alloc_id_o=0.
- Same-cycle alloc and retire with count_o=5 -> count_o stays 5, head and tail both +1.
- resp_id_i=7 while outstanding is [0,3) -> err_o=1 and stays high; ret_id_o=0 is unaffected.
- Assert rst mid-lap (head=3, tail=9) -> all outputs at reset values asynchronously; after release, clear pulse, then alloc_id_o=0.
